// File: rtl/flag_counter_pkg.sv
// Shared types and defaults for the flag counter.
// The optional edge-triggered mode is selected with FLAG_COUNTER_EDGE_EN.
package flag_counter_pkg;

  localparam int FC_WIDTH     = 2;
  localparam int FC_THRESHOLD = 3;

  typedef logic [FC_WIDTH-1:0] flag_cnt_t;

  typedef enum logic {
    FC_COUNTING = 1'b0,
    FC_DONE     = 1'b1
  } fc_state_e;

endpackage : flag_counter_pkg

// File: rtl/flag_counter_edge.sv
// Rising-edge detector for the trigger flag.
// Only used when FLAG_COUNTER_EDGE_EN is defined.
module flag_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_trigger,
  output logic o_rise
);

  logic r_trig_d;

  // Keeps tracking trigger in every state so a level held through DONE is not re-counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_d <= 1'b0;
    end else begin
      r_trig_d <= i_trigger;
    end
  end

  assign o_rise = i_trigger & ~r_trig_d;

endmodule : flag_edge_detect

// File: rtl/flag_counter.sv
// Counts trigger events and raises a sticky gameover flag at THRESHOLD.
// Define FLAG_COUNTER_EDGE_EN to count rising edges of trigger instead of high cycles.
module flag_counter
  import flag_counter_pkg::*;
#(
  parameter int WIDTH     = FC_WIDTH,
  parameter int THRESHOLD = FC_THRESHOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  output logic             gameover,
  output logic [WIDTH-1:0] count
);

  if (THRESHOLD < 1 || THRESHOLD > (2 ** WIDTH) - 1) begin : g_bad_threshold
    $error("flag_counter: THRESHOLD %0d outside 1..2**WIDTH-1", THRESHOLD);
  end

  localparam logic [WIDTH-1:0] THR_LAST = WIDTH'(THRESHOLD - 1);

  logic             w_event;
  logic [WIDTH-1:0] r_count;
  fc_state_e        r_state;

`ifdef FLAG_COUNTER_EDGE_EN
  flag_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .i_trigger (trigger),
    .o_rise    (w_event)
  );
`else
  assign w_event = trigger;
`endif

  // Reaching the last step moves to DONE on the same edge the count lands on THRESHOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FC_COUNTING;
      r_count <= '0;
    end else if (r_state == FC_COUNTING && w_event) begin
      r_count <= r_count + WIDTH'(1);
      if (r_count == THR_LAST) begin
        r_state <= FC_DONE;
      end
    end
  end

  assign count    = r_count;
  assign gameover = (r_state == FC_DONE);

  a_trigger_known : assert property (@(posedge clk) disable iff (rst) !$isunknown(trigger));

endmodule : flag_counter

// File: tb/tb_flag_counter.sv
// Directed bench for flag_counter (default level-sensitive build),
// plus a WIDTH=4/THRESHOLD=10 instance for the parameter override.
module tb_flag_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic       gameover;
  logic [1:0] count;

  logic       rst2;
  logic       trigger2;
  logic       gameover2;
  logic [3:0] count2;

  int checks   = 0;
  int failures = 0;

  always #20 clk = ~clk;

  flag_counter dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .gameover (gameover),
    .count    (count)
  );

  flag_counter #(.WIDTH(4), .THRESHOLD(10)) dut_wide (
    .clk      (clk),
    .rst      (rst2),
    .trigger  (trigger2),
    .gameover (gameover2),
    .count    (count2)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1 ns after the edge and check.
  task automatic step(input string tag, input logic r, input logic t,
                      input logic [1:0] exp_cnt, input logic exp_go);
    rst     = r;
    trigger = t;
    @(posedge clk);
    #1;
    $display("%s rst=%0d trig=%0d count=%0d gameover=%0d", tag, r, t, count, gameover);
    chk({tag, ".count"}, {2'b00, count}, {2'b00, exp_cnt});
    chk({tag, ".gameover"}, {3'b000, gameover}, {3'b000, exp_go});
  endtask

  initial begin
    int exp_c;
    logic t;
    rst      = 1'b1;
    trigger  = 1'b1;
    rst2     = 1'b1;
    trigger2 = 1'b0;
    #1;

    // Reset with trigger high: rst has priority
    step("rst0", 1'b1, 1'b1, 2'd0, 1'b0);
    step("rst1", 1'b1, 1'b1, 2'd0, 1'b0);

    // Level counting up to threshold, then sticky
    step("lvl1", 1'b0, 1'b1, 2'd1, 1'b0);
    step("lvl2", 1'b0, 1'b1, 2'd2, 1'b0);
    step("lvl3", 1'b0, 1'b1, 2'd3, 1'b1);
    step("lvl4", 1'b0, 1'b1, 2'd3, 1'b1);
    step("lvl5", 1'b0, 1'b1, 2'd3, 1'b1);
    step("idle", 1'b0, 1'b0, 2'd3, 1'b1);

    // Reset from DONE with trigger high
    step("rstd", 1'b1, 1'b1, 2'd0, 1'b0);

    // Gapped triggers
    step("gap1", 1'b0, 1'b1, 2'd1, 1'b0);
    step("gap2", 1'b0, 1'b0, 2'd1, 1'b0);
    step("gap3", 1'b0, 1'b1, 2'd2, 1'b0);
    step("gap4", 1'b0, 1'b0, 2'd2, 1'b0);
    step("gap5", 1'b0, 1'b1, 2'd3, 1'b1);

    // Reset mid-count, counting resumes from zero
    step("mid1", 1'b1, 1'b0, 2'd0, 1'b0);
    step("mid2", 1'b0, 1'b1, 2'd1, 1'b0);
    step("mid3", 1'b1, 1'b1, 2'd0, 1'b0);

    // Toggling trigger for a 1400 ns run (35 clocks), starting high
    exp_c = 0;
    for (int i = 0; i < 35; i++) begin
      t = (i % 2 == 0);
      if (t && exp_c < 3) exp_c++;
      step($sformatf("tog%0d", i), 1'b0, t, 2'(exp_c), (exp_c == 3));
    end

    // Wide instance: gameover on the 10th counted event, then holds at 10
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    chk("wide.rst", count2, 4'd0);
    rst2     = 1'b0;
    trigger2 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      $display("wide%0d count=%0d gameover=%0d", i, count2, gameover2);
      chk($sformatf("wide%0d.count", i), count2, (i >= 10) ? 4'd10 : 4'(i));
      chk($sformatf("wide%0d.gameover", i), {3'b000, gameover2}, {3'b000, (i >= 10)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_flag_counter
